// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative multiply/divide unit with architectural HI/LO registers
// Optional MDU_FAST_MUL_EN: MULT/MULTU use a single-cycle multiplier instead of shift-add.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] mt_data,
    input  logic             read_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic [WIDTH-1:0]   raw_a_q, raw_a_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dbz_pend_q, dbz_pend_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_trial;
    logic               div_ok;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // op[0]=0 selects the signed variants; magnitudes feed the unsigned datapath
    assign sign_a = ~op[0] & src_a[WIDTH-1];
    assign sign_b = ~op[0] & src_b[WIDTH-1];
    assign abs_a  = sign_a ? (~src_a + 1'b1) : src_a;
    assign abs_b  = sign_b ? (~src_b + 1'b1) : src_b;

    // work_q holds {partial product, remaining multiplier} during MUL
    assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]}
                    + (work_q[0] ? {1'b0, mag_q} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, work_q[WIDTH-1:1]};

    // work_q holds {partial remainder, dividend/quotient} during DIV
    assign div_trial = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]} - {1'b0, mag_q};
    assign div_ok    = ~div_trial[WIDTH];
    assign rem_next  = div_ok ? div_trial[WIDTH-1:0]
                              : {work_q[2*WIDTH-2:WIDTH], work_q[WIDTH-1]};
    assign div_next  = {rem_next, work_q[WIDTH-2:0], div_ok};

    assign prod_fix = neg_q ? (~work_q + 1'b1) : work_q;
    assign quo_fix  = neg_q ? (~work_q[WIDTH-1:0] + 1'b1) : work_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? (~work_q[2*WIDTH-1:WIDTH] + 1'b1)
                                : work_q[2*WIDTH-1:WIDTH];

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            work_q     <= '0;
            mag_q      <= '0;
            raw_a_q    <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            neg_rem_q  <= 1'b0;
            dbz_pend_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            mag_q      <= mag_d;
            raw_a_q    <= raw_a_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            neg_rem_q  <= neg_rem_d;
            dbz_pend_q <= dbz_pend_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        mag_d      = mag_q;
        raw_a_d    = raw_a_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        neg_rem_d  = neg_rem_q;
        dbz_pend_d = dbz_pend_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        dbz_d      = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d      = CW'(WIDTH - 1);
                    raw_a_d    = src_a;
                    is_div_d   = op[1];
                    neg_d      = sign_a ^ sign_b;
                    neg_rem_d  = sign_a;
                    dbz_pend_d = op[1] && (src_b == '0);
                    dbz_d      = 1'b0;
                    if (op[1]) begin
                        work_d  = {{WIDTH{1'b0}}, abs_a};
                        mag_d   = abs_b;
                        state_d = S_DIV;
                    end else begin
`ifdef MDU_FAST_MUL_EN
                        work_d  = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
                        state_d = S_FIX;
`else
                        work_d  = {{WIDTH{1'b0}}, abs_b};
                        mag_d   = abs_a;
                        state_d = S_MUL;
`endif
                    end
                end else begin
                    if (mthi) hi_d = mt_data;
                    if (mtlo) lo_d = mt_data;
                end
            end
            S_MUL: begin
                work_d = mul_next;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == '0) state_d = S_FIX;
            end
            S_DIV: begin
                work_d = div_next;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == '0) state_d = S_FIX;
            end
            S_FIX: begin
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (dbz_pend_q) begin
                    lo_d  = '1;
                    hi_d  = raw_a_q;
                    dbz_d = 1'b1;
                end else begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign stall       = busy & (start | read_req | mthi | mtlo);
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed and random checks of mul_div_unit against an arithmetic model
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         rst, start, mthi, mtlo, read_req;
    logic [1:0]   op;
    logic [W-1:0] src_a, src_b, mt_data;
    logic [W-1:0] hi, lo;
    logic         busy, stall, done, div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clock(clock), .rst(rst), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .mthi(mthi), .mtlo(mtlo),
        .mt_data(mt_data), .read_req(read_req),
        .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done),
        .div_by_zero(div_by_zero)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, expected end before time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: full-width integer arithmetic; SV division truncates toward zero
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el, output logic edz);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        edz = 1'b0;
        eh  = '0;
        el  = '0;
        case (o)
            2'd0: begin p = sa * sb; {eh, el} = p; end
            2'd1: begin p = {32'b0, a} * {32'b0, b}; {eh, el} = p; end
            default: begin
                if (b == 0) begin
                    el = '1; eh = a; edz = 1'b1;
                end else if (o == 2'd2) begin
                    q = sa / sb; r = sa % sb;
                    el = q[31:0]; eh = r[31:0];
                end else begin
                    el = a / b; eh = a % b;
                end
            end
        endcase
    endtask

    function automatic int exp_lat(input logic [1:0] o);
`ifdef MDU_FAST_MUL_EN
        return o[1] ? W + 1 : 1;
`else
        return W + 1;
`endif
    endfunction

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        logic [31:0] eh, el, hi0, lo0;
        logic        edz;
        int          edges, busy_cyc;
        bit          hold_ok;
        model(o, a, b, eh, el, edz);
        @(negedge clock);
        hi0 = hi; lo0 = lo;
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clock);
        start = 1'b0;
        edges = 1; busy_cyc = 0; hold_ok = 1'b1;
        while (done !== 1'b1 && edges < 100) begin
            if (busy === 1'b1) busy_cyc++;
            if (hi !== hi0 || lo !== lo0) hold_ok = 1'b0;
            @(negedge clock);
            edges++;
        end
        check($sformatf("%s.latency", tag), 64'(edges - 1), 64'(exp_lat(o)));
        check($sformatf("%s.busy_cycles", tag), 64'(busy_cyc), 64'(exp_lat(o)));
        check($sformatf("%s.hold", tag), 64'(hold_ok), 64'd1);
        check($sformatf("%s.hi", tag), 64'(hi), 64'(eh));
        check($sformatf("%s.lo", tag), 64'(lo), 64'(el));
        check($sformatf("%s.dbz", tag), 64'(div_by_zero), 64'(edz));
        check($sformatf("%s.busy_at_done", tag), 64'(busy), 64'd0);
        @(negedge clock);
        check($sformatf("%s.done_width", tag), 64'(done), 64'd0);
    endtask

    initial begin
        logic [31:0] eh1, el1, eh2, el2, lo_prev;
        logic        edz1, edz2;
        int          edges;
        bit          stall_ok, mt_ok, saw_done;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        rst = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0;
        mthi = 1'b0; mtlo = 1'b0; mt_data = '0; read_req = 1'b0;
        repeat (2) @(negedge clock);
        check("reset.hi", 64'(hi), 64'd0);
        check("reset.lo", 64'(lo), 64'd0);
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.dbz", 64'(div_by_zero), 64'd0);
        check("reset.stall", 64'(stall), 64'd0);
        rst = 1'b0;

        do_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
        check("tp.multu.hi", 64'(hi), 64'hFFFFFFFE);
        check("tp.multu.lo", 64'(lo), 64'h00000001);
        do_op(2'd0, 32'hFFFFFFFD, 32'd7, "mult_neg");
        check("tp.mult.hi", 64'(hi), 64'hFFFFFFFF);
        check("tp.mult.lo", 64'(lo), 64'hFFFFFFEB);
        do_op(2'd2, 32'hFFFFFFF9, 32'd2, "div_neg");
        check("tp.div.lo", 64'(lo), 64'hFFFFFFFD);
        check("tp.div.hi", 64'(hi), 64'hFFFFFFFF);
        do_op(2'd3, 32'd9, 32'd0, "divu_zero");
        check("tp.dbz.lo", 64'(lo), 64'hFFFFFFFF);
        check("tp.dbz.hi", 64'(hi), 64'h9);
        check("tp.dbz.flag", 64'(div_by_zero), 64'd1);
        do_op(2'd3, 32'd9, 32'd3, "divu_clear");
        check("tp.divu.lo", 64'(lo), 64'd3);
        check("tp.divu.flag", 64'(div_by_zero), 64'd0);
        do_op(2'd2, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
        check("tp.ovf.lo", 64'(lo), 64'h80000000);
        check("tp.ovf.hi", 64'(hi), 64'd0);
        do_op(2'd2, 32'd7, 32'hFFFFFFFE, "div_pos_neg");
        do_op(2'd0, 32'h80000000, 32'h80000000, "mult_minmin");
        do_op(2'd2, 32'h12345678, 32'd0, "div_zero_signed");

        // MT writes and read_req in IDLE
        @(negedge clock);
        mthi = 1'b1; mtlo = 1'b1; mt_data = 32'hA5A5C3C3; read_req = 1'b1;
        check("idle.read_stall", 64'(stall), 64'd0);
        @(negedge clock);
        mthi = 1'b0; mtlo = 1'b0; read_req = 1'b0;
        check("mt_both.hi", 64'(hi), 64'hA5A5C3C3);
        check("mt_both.lo", 64'(lo), 64'hA5A5C3C3);
        mthi = 1'b1; mt_data = 32'h12345678;
        @(negedge clock);
        mthi = 1'b0;
        check("mthi.hi", 64'(hi), 64'h12345678);
        check("mthi.lo_kept", 64'(lo), 64'hA5A5C3C3);

        // start with MTLO: start wins; then reset at E10 aborts
        lo_prev = lo;
        start = 1'b1; op = 2'd1; src_a = 32'd5; src_b = 32'd6;
        mtlo = 1'b1; mt_data = 32'hCAFEF00D;
        @(negedge clock);
        start = 1'b0; mtlo = 1'b0;
        check("start_wins.lo", 64'(lo), 64'(lo_prev));
        check("start_wins.busy", 64'(busy), 64'd1);
        repeat (9) @(negedge clock);
`ifndef MDU_FAST_MUL_EN
        check("pre_abort.busy", 64'(busy), 64'd1);
`endif
        rst = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        check("abort.hi", 64'(hi), 64'd0);
        check("abort.lo", 64'(lo), 64'd0);
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.done", 64'(done), 64'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        check("abort.no_done", 64'(saw_done), 64'd0);

        // Stall while busy: read_req, second start and MTLO all held off
        model(2'd2, 32'hFFFFFFF9, 32'd2, eh1, el1, edz1);
        model(2'd3, 32'd100, 32'd7, eh2, el2, edz2);
        @(negedge clock);
        start = 1'b1; op = 2'd2; src_a = 32'hFFFFFFF9; src_b = 32'd2;
        @(negedge clock);
        op = 2'd3; src_a = 32'd100; src_b = 32'd7;
        read_req = 1'b1; mtlo = 1'b1; mt_data = 32'hDEADBEEF;
        lo_prev = lo; edges = 1; stall_ok = 1'b1; mt_ok = 1'b1;
        while (done !== 1'b1 && edges < 100) begin
            if (stall !== 1'b1) stall_ok = 1'b0;
            if (lo !== lo_prev) mt_ok = 1'b0;
            @(negedge clock);
            edges++;
        end
        check("stall.every_busy", 64'(stall_ok), 64'd1);
        check("stall.mt_ignored", 64'(mt_ok), 64'd1);
        check("stall.latency", 64'(edges - 1), 64'(W + 1));
        check("stall.after_fix", 64'(stall), 64'd0);
        check("stall.first.hi", 64'(hi), 64'(eh1));
        check("stall.first.lo", 64'(lo), 64'(el1));
        @(negedge clock);
        check("second.accepted", 64'(busy), 64'd1);
        check("second.mt_dropped", 64'(lo), 64'(el1));
        start = 1'b0; read_req = 1'b0; mtlo = 1'b0;
        edges = 1;
        while (done !== 1'b1 && edges < 100) begin
            @(negedge clock);
            edges++;
        end
        check("second.latency", 64'(edges - 1), 64'(W + 1));
        check("second.hi", 64'(hi), 64'(eh2));
        check("second.lo", 64'(lo), 64'(el2));

        // Random operations
        for (int i = 0; i < 16; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 :
                 ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 50));
            do_op(ro, ra, rb, $sformatf("rand%0d_op%0d", i, ro));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
